// File: rtl/combo_prog_lockout.sv
// rtl/combo_prog_lockout.sv - combination store, programming sequencer and failed-attempt lockout
//
// Holds the three active combination digits and returns the one picked by
// i_sel (registered) to the dial comparator. While the safe is open it walks
// the user through entering a new three-digit combination, committing all
// three digits at once. Counts consecutive failed unlock attempts and raises
// a timed lockout once the limit is hit.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-high reset
//   i_safe_open    master reports the safe is unlocked
//   i_prog_req     pulse, start programming a new combination
//   i_enter        pulse, capture i_dial_val as the next digit
//   i_abort        pulse, cancel programming
//   i_dial_val     current dial position
//   i_sel          digit index requested by the master FSM
//   i_attempt_ok   pulse, unlock attempt succeeded
//   i_attempt_fail pulse, unlock attempt failed
//   o_combo_out    active digit chosen by i_sel, one cycle latency
//   o_prog_active  programming in progress
//   o_prog_done    pulse, new combination committed
//   o_prog_err     pulse, programming rejected or cancelled
//   o_lockout      attempts are blocked
//   o_fail_cnt     consecutive failure count
module combo_prog_lockout #(
    parameter int DIAL_W      = 6,
    parameter int DIAL_MAX    = 39,
    parameter int MAX_FAIL    = 3,
    parameter int LOCKOUT_CYC = 1000,
    parameter int DEF0        = 10,
    parameter int DEF1        = 20,
    parameter int DEF2        = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_safe_open,
    input  logic              i_prog_req,
    input  logic              i_enter,
    input  logic              i_abort,
    input  logic [DIAL_W-1:0] i_dial_val,
    input  logic [1:0]        i_sel,
    input  logic              i_attempt_ok,
    input  logic              i_attempt_fail,
    output logic [DIAL_W-1:0] o_combo_out,
    output logic              o_prog_active,
    output logic              o_prog_done,
    output logic              o_prog_err,
    output logic              o_lockout,
    output logic [3:0]        o_fail_cnt
);

    localparam logic [DIAL_W-1:0] L_DIAL_MAX = DIAL_MAX[DIAL_W-1:0];
    localparam logic [DIAL_W-1:0] L_DEF0     = DEF0[DIAL_W-1:0];
    localparam logic [DIAL_W-1:0] L_DEF1     = DEF1[DIAL_W-1:0];
    localparam logic [DIAL_W-1:0] L_DEF2     = DEF2[DIAL_W-1:0];
    localparam logic [3:0]        L_MAX_FAIL = MAX_FAIL[3:0];
    localparam int                LOCK_INIT  = LOCKOUT_CYC - 1;
    localparam logic [15:0]       L_LOCK_INIT = LOCK_INIT[15:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CAP0   = 3'd1,
        S_CAP1   = 3'd2,
        S_CAP2   = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DIAL_W-1:0] r_active [3];
    logic [DIAL_W-1:0] r_shadow [3];
    logic [DIAL_W-1:0] r_combo_out;
    logic              r_prog_active;
    logic              r_prog_done;
    logic              r_prog_err;
    logic              r_lockout;
    logic [3:0]        r_fail_cnt;
    logic [15:0]       r_timer;

    logic              w_in_cap;
    logic              w_cancel;
    logic              w_legal;
    logic              w_cap_wr;
    logic              w_err;
    logic              w_commit;

    // State register plus every registered output of the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_active[0]   <= L_DEF0;
            r_active[1]   <= L_DEF1;
            r_active[2]   <= L_DEF2;
            r_shadow[0]   <= '0;
            r_shadow[1]   <= '0;
            r_shadow[2]   <= '0;
            r_prog_active <= 1'b0;
            r_prog_done   <= 1'b0;
            r_prog_err    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_prog_active <= (w_next_state != S_IDLE);
            r_prog_done   <= (w_next_state == S_COMMIT);
            r_prog_err    <= w_err;
            if (w_cap_wr) begin
                case (r_state)
                    S_CAP0:  r_shadow[0] <= i_dial_val;
                    S_CAP1:  r_shadow[1] <= i_dial_val;
                    default: r_shadow[2] <= i_dial_val;
                endcase
            end
            // All three digits move together so a cancelled entry never
            // leaves a mixed combination behind.
            if (w_commit) begin
                r_active[0] <= r_shadow[0];
                r_active[1] <= r_shadow[1];
                r_active[2] <= r_shadow[2];
            end
        end
    end

    // Next-state logic; cancel (abort or safe closing) outranks enter.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_prog_req && i_safe_open && !r_lockout)
                    w_next_state = S_CAP0;
            end
            S_CAP0, S_CAP1, S_CAP2: begin
                if (!i_safe_open || i_abort) begin
                    w_next_state = S_IDLE;
                end else if (i_enter) begin
                    if (i_dial_val > L_DIAL_MAX)
                        w_next_state = S_IDLE;
                    else if (r_state == S_CAP0)
                        w_next_state = S_CAP1;
                    else if (r_state == S_CAP1)
                        w_next_state = S_CAP2;
                    else
                        w_next_state = S_COMMIT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode feeding the registers above.
    always_comb begin
        w_in_cap = (r_state == S_CAP0) || (r_state == S_CAP1) || (r_state == S_CAP2);
        w_cancel = !i_safe_open || i_abort;
        w_legal  = (i_dial_val <= L_DIAL_MAX);
        w_cap_wr = w_in_cap && !w_cancel && i_enter && w_legal;
        w_err    = w_in_cap && (w_cancel || (i_enter && !w_legal));
        w_commit = (r_state == S_COMMIT);
    end

    // Digit readback; sel=3 aliases digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_combo_out <= L_DEF0;
        end else begin
            case (i_sel)
                2'd1:    r_combo_out <= r_active[1];
                2'd2:    r_combo_out <= r_active[2];
                default: r_combo_out <= r_active[0];
            endcase
        end
    end

    // Failure counter and lockout timer. Attempts are ignored while locked;
    // the cycle in which the timer reads zero is the last lockout cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lockout  <= 1'b0;
            r_fail_cnt <= 4'd0;
            r_timer    <= 16'd0;
        end else if (r_lockout) begin
            if (r_timer == 16'd0) begin
                r_lockout  <= 1'b0;
                r_fail_cnt <= 4'd0;
            end else begin
                r_timer <= r_timer - 16'd1;
            end
        end else if (i_attempt_ok) begin
            r_fail_cnt <= 4'd0;
        end else if (i_attempt_fail && (r_fail_cnt < L_MAX_FAIL)) begin
            r_fail_cnt <= r_fail_cnt + 4'd1;
            if (r_fail_cnt + 4'd1 == L_MAX_FAIL) begin
                r_lockout <= 1'b1;
                r_timer   <= L_LOCK_INIT;
            end
        end
    end

    assign o_combo_out   = r_combo_out;
    assign o_prog_active = r_prog_active;
    assign o_prog_done   = r_prog_done;
    assign o_prog_err    = r_prog_err;
    assign o_lockout     = r_lockout;
    assign o_fail_cnt    = r_fail_cnt;

endmodule

// File: tb/tb_combo_prog_lockout.sv
// tb/tb_combo_prog_lockout.sv - directed self-checking bench for combo_prog_lockout
module tb_combo_prog_lockout;

    logic       clk;
    logic       rst;
    logic       safe_open;
    logic       prog_req;
    logic       enter;
    logic       abort;
    logic [5:0] dial_val;
    logic [1:0] sel;
    logic       attempt_ok;
    logic       attempt_fail;
    logic [5:0] combo_out;
    logic       prog_active;
    logic       prog_done;
    logic       prog_err;
    logic       lockout;
    logic [3:0] fail_cnt;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int err_seen = 0;

    combo_prog_lockout dut (
        .clk            (clk),
        .rst            (rst),
        .i_safe_open    (safe_open),
        .i_prog_req     (prog_req),
        .i_enter        (enter),
        .i_abort        (abort),
        .i_dial_val     (dial_val),
        .i_sel          (sel),
        .i_attempt_ok   (attempt_ok),
        .i_attempt_fail (attempt_fail),
        .o_combo_out    (combo_out),
        .o_prog_active  (prog_active),
        .o_prog_done    (prog_done),
        .o_prog_err     (prog_err),
        .o_lockout      (lockout),
        .o_fail_cnt     (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_done) done_seen++;
        if (prog_err) err_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic enter_digit(input logic [5:0] v);
        dial_val = v;
        enter = 1'b1;
        step();
        enter = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (combo_out !== 6'd10) begin errors++; $display("FAIL reset_combo got %0d exp 10", combo_out); end
        checks++;
        if ({prog_active, prog_done, prog_err, lockout} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {prog_active, prog_done, prog_err, lockout});
        end
        checks++;
        if (fail_cnt !== 4'd0) begin errors++; $display("FAIL reset_fail_cnt got %0d exp 0", fail_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_sel();
        logic [5:0] exp_v [4];
        exp_v[0] = 6'd10; exp_v[1] = 6'd20; exp_v[2] = 6'd30; exp_v[3] = 6'd10;
        sel = 2'd1;
        #1;
        checks++;
        if (combo_out !== 6'd10) begin errors++; $display("FAIL sel_latency got %0d exp 10", combo_out); end
        for (int i = 1; i < 4; i++) begin
            sel = i[1:0];
            step();
            checks++;
            if (combo_out !== exp_v[i]) begin errors++; $display("FAIL sel%0d_combo got %0d exp %0d", i, combo_out, exp_v[i]); end
        end
        sel = 2'd0;
        step();
        checks++;
        if (combo_out !== 6'd10) begin errors++; $display("FAIL sel0_combo got %0d exp 10", combo_out); end
    endtask

    task automatic test_prog_ok();
        int e0;
        logic [5:0] exp_v [3];
        exp_v[0] = 6'd5; exp_v[1] = 6'd17; exp_v[2] = 6'd33;
        e0 = err_seen;
        safe_open = 1'b1;
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
        checks++;
        if (prog_active !== 1'b1) begin errors++; $display("FAIL prog_active_rise got %b exp 1", prog_active); end
        enter_digit(6'd5);
        enter_digit(6'd17);
        enter_digit(6'd33);
        checks++;
        if ({prog_done, prog_active} !== 2'b11) begin errors++; $display("FAIL commit_cycle got done,active=%b exp 11", {prog_done, prog_active}); end
        step();
        checks++;
        if ({prog_done, prog_active} !== 2'b00) begin errors++; $display("FAIL after_commit got done,active=%b exp 00", {prog_done, prog_active}); end
        for (int i = 0; i < 3; i++) begin
            sel = i[1:0];
            step();
            checks++;
            if (combo_out !== exp_v[i]) begin errors++; $display("FAIL new_combo%0d got %0d exp %0d", i, combo_out, exp_v[i]); end
        end
        sel = 2'd0;
        checks++;
        if (err_seen != e0) begin errors++; $display("FAIL prog_ok_err got %0d pulses exp 0", err_seen - e0); end
    endtask

    task automatic check_defaults(input string tag);
        logic [5:0] exp_v [3];
        exp_v[0] = 6'd10; exp_v[1] = 6'd20; exp_v[2] = 6'd30;
        for (int i = 0; i < 3; i++) begin
            sel = i[1:0];
            step();
            checks++;
            if (combo_out !== exp_v[i]) begin errors++; $display("FAIL %s_digit%0d got %0d exp %0d", tag, i, combo_out, exp_v[i]); end
        end
        sel = 2'd0;
    endtask

    task automatic test_bad_digit();
        do_reset();
        safe_open = 1'b1;
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
        enter_digit(6'd8);
        checks++;
        if (prog_active !== 1'b1) begin errors++; $display("FAIL bad_mid_active got %b exp 1", prog_active); end
        enter_digit(6'd45);
        checks++;
        if ({prog_err, prog_active, prog_done} !== 3'b100) begin
            errors++; $display("FAIL bad_digit got err,active,done=%b exp 100", {prog_err, prog_active, prog_done});
        end
        step();
        checks++;
        if (prog_err !== 1'b0) begin errors++; $display("FAIL bad_err_pulse got %b exp 0", prog_err); end
        check_defaults("bad");
    endtask

    task automatic test_abort();
        int d0;
        do_reset();
        d0 = done_seen;
        safe_open = 1'b1;
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
        enter_digit(6'd1);
        abort = 1'b1;
        enter_digit(6'd2);
        abort = 1'b0;
        checks++;
        if ({prog_err, prog_active} !== 2'b10) begin errors++; $display("FAIL abort_enter got err,active=%b exp 10", {prog_err, prog_active}); end
        step();
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
        enter_digit(6'd1);
        enter_digit(6'd2);
        safe_open = 1'b0;
        step();
        safe_open = 1'b1;
        checks++;
        if ({prog_err, prog_active} !== 2'b10) begin errors++; $display("FAIL close_cap2 got err,active=%b exp 10", {prog_err, prog_active}); end
        check_defaults("abort");
        checks++;
        if (done_seen != d0) begin errors++; $display("FAIL abort_commit got %0d done pulses exp 0", done_seen - d0); end
    endtask

    task automatic test_lockout();
        int hi;
        do_reset();
        safe_open = 1'b1;
        for (int i = 0; i < 3; i++) begin
            attempt_fail = 1'b1;
            step();
            attempt_fail = 1'b0;
        end
        checks++;
        if ({lockout, fail_cnt} !== 5'b1_0011) begin errors++; $display("FAIL lock_enter got lockout,cnt=%b exp 10011", {lockout, fail_cnt}); end
        attempt_fail = 1'b1;
        prog_req = 1'b1;
        step();
        attempt_fail = 1'b0;
        prog_req = 1'b0;
        checks++;
        if ({lockout, fail_cnt, prog_active} !== 6'b1_0011_0) begin
            errors++; $display("FAIL lock_ignore got lockout,cnt,active=%b exp 100110", {lockout, fail_cnt, prog_active});
        end
        hi = 2;
        for (int i = 0; i < 1100 && lockout; i++) begin
            step();
            if (lockout) hi++;
        end
        checks++;
        if (hi != 1000) begin errors++; $display("FAIL lock_duration got %0d cycles exp 1000", hi); end
        checks++;
        if ({lockout, fail_cnt} !== 5'b0_0000) begin errors++; $display("FAIL lock_exit got lockout,cnt=%b exp 00000", {lockout, fail_cnt}); end
    endtask

    task automatic test_ok_wins();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            attempt_fail = 1'b1;
            step();
            attempt_fail = 1'b0;
        end
        checks++;
        if (fail_cnt !== 4'd2) begin errors++; $display("FAIL two_fails got %0d exp 2", fail_cnt); end
        attempt_ok = 1'b1;
        attempt_fail = 1'b1;
        step();
        attempt_ok = 1'b0;
        attempt_fail = 1'b0;
        checks++;
        if ({lockout, fail_cnt} !== 5'b0_0000) begin errors++; $display("FAIL ok_wins got lockout,cnt=%b exp 00000", {lockout, fail_cnt}); end
        attempt_fail = 1'b1;
        step();
        attempt_fail = 1'b0;
        checks++;
        if ({lockout, fail_cnt} !== 5'b0_0001) begin errors++; $display("FAIL fail_after_ok got lockout,cnt=%b exp 00001", {lockout, fail_cnt}); end
    endtask

    initial begin
        rst = 1'b1;
        safe_open = 1'b0;
        prog_req = 1'b0;
        enter = 1'b0;
        abort = 1'b0;
        dial_val = 6'd0;
        sel = 2'd0;
        attempt_ok = 1'b0;
        attempt_fail = 1'b0;
        test_reset();
        test_sel();
        test_prog_ok();
        test_bad_digit();
        test_abort();
        test_lockout();
        test_ok_wins();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/combo_prog_lockout.md
Name: combo_prog_lockout

Overview:
Combination store and attempt supervisor for the safe. Holds the three active combination values and returns the one chosen by the master FSM's sel, registered, to the dial comparator. While the safe is open it sequences user entry of a new combination. It counts failed unlock attempts and asserts a timed lockout that the master uses to gate its open input.

Parameters:
DIAL_W, 6, width of dial value
DIAL_MAX, 39, highest legal dial position; values above are illegal
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..15)
LOCKOUT_CYC, 1000, lockout duration in clk cycles (>=1, fits 16 bits)
DEF0, 10, reset value of combination digit 0
DEF1, 20, reset value of combination digit 1
DEF2, 30, reset value of combination digit 2

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
safe_open  input  1  master reports unlocked state
prog_req  input  1  one-cycle pulse, start programming
enter  input  1  one-cycle pulse, capture dial_val as next digit
abort  input  1  one-cycle pulse, cancel programming
dial_val  input  DIAL_W  current dial position
sel  input  2  digit index from master FSM
attempt_ok  input  1  one-cycle pulse, unlock succeeded
attempt_fail  input  1  one-cycle pulse, attempt ended bad
combo_out  output  DIAL_W  active digit selected by sel, registered
prog_active  output  1  programming in progress
prog_done  output  1  one-cycle pulse, new combination committed
prog_err  output  1  one-cycle pulse, programming rejected or cancelled
lockout  output  1  attempts blocked
fail_cnt  output  4  consecutive failure count

Behaviour:
- Reset, asynchronous, all registers: active[0..2]=DEF0..DEF2; shadow regs=0; combo_out=DEF0; prog_active=0; prog_done=0; prog_err=0; lockout=0; fail_cnt=0; timer=0; state=IDLE.
- combo_out: registered at each clk; sel 0/1/2 selects active[0]/[1]/[2]; sel=3 selects active[0]. Latency 1 cycle.
- Programming FSM states: IDLE, CAP0, CAP1, CAP2, COMMIT.
- IDLE -> CAP0 when prog_req && safe_open && !lockout. Otherwise prog_req is ignored with no error.
- CAPn on enter: if dial_val<=DIAL_MAX, shadow[n]<=dial_val and go to next state (CAP2 goes to COMMIT). If dial_val>DIAL_MAX, prog_err pulses and go to IDLE.
- COMMIT: lasts 1 cycle. Copy shadow[0..2] to active[0..2] together and pulse prog_done. Next state IDLE. The new values are visible on combo_out on the following cycle.
- In CAP0..CAP2, abort or a 0 on safe_open forces IDLE with a prog_err pulse. This has priority over enter in the same cycle. active is never partially updated.
- prog_active=1 in CAP0, CAP1, CAP2 and COMMIT. It is registered from the next-state value, so it rises in the cycle the FSM enters CAP0.
- prog_done and prog_err are single-cycle registered pulses and are never high together.
- Failure counter, when not in lockout:
  - attempt_ok clears fail_cnt.
  - attempt_fail increments fail_cnt.
  - If both pulse in the same cycle, attempt_ok wins.
- When an increment makes fail_cnt reach MAX_FAIL: in the next cycle lockout=1 and timer=LOCKOUT_CYC-1. fail_cnt holds MAX_FAIL.
- During lockout:
  - timer decrements each cycle.
  - When the cycle with timer==0 ends, lockout=0 and fail_cnt=0.
  - lockout therefore stays high for exactly LOCKOUT_CYC cycles.
  - attempt_ok and attempt_fail are ignored.
- fail_cnt saturates at MAX_FAIL and never wraps.
- Reset mid-programming or mid-lockout returns everything to reset values, including the DEF combination.

Test Plan:
- Reset then sel=0,1,2,3 -> combo_out=10,20,30,10, each one cycle after sel changes.
- safe_open=1, prog_req, then enter with dial_val=5, 17, 33 -> prog_done pulse in the COMMIT cycle. Then sel=0,1,2 -> 5, 17, 33. prog_err never asserted.
- Programming, digit 1 entered as 45 -> prog_err pulse, return to IDLE, active still 10/20/30, prog_active=0.
- Programming, abort pulsed in the same cycle as the 2nd enter -> prog_err, no commit. safe_open dropped in CAP2 -> prog_err, no commit.
- 3x attempt_fail -> fail_cnt=3, lockout=1 for exactly 1000 cycles, then fail_cnt=0. An attempt_fail pulsed during lockout leaves fail_cnt=3. prog_req during lockout is ignored.
- 2x attempt_fail, then attempt_ok and attempt_fail in the same cycle -> fail_cnt=0, no lockout.
